// File: rtl/ofdm_frame_sync_if.sv
// Sample-stream bus of the OFDM receive frame synchroniser: I/Q samples and
// clear go in, lock status and the frame-start strobe come back.
interface ofdm_frame_sync_if #(
  parameter int DATA_SIZE = 16
);
  logic                        en;
  logic signed [DATA_SIZE-1:0] in_data_i;
  logic signed [DATA_SIZE-1:0] in_data_q;
  logic                        clear;
  logic                        locked;
  logic                        frame_start;
  logic                        metric_ok;

  modport master (
    output en, in_data_i, in_data_q, clear,
    input  locked, frame_start, metric_ok
  );

  modport slave (
    input  en, in_data_i, in_data_q, clear,
    output locked, frame_start, metric_ok
  );
endinterface

// File: rtl/ofdm_frame_sync.sv
// Delay-and-correlate short-preamble detector with plateau lock and frame-start strobe.
// Optional LOCKED auto-release after FRAME_LEN samples: define OFDM_SYNC_TIMEOUT_EN.
module ofdm_frame_sync #(
  parameter int DATA_SIZE = 16,
  parameter int DELAY     = 16,
  parameter int WIN_LOG2  = 4,
  parameter int PLATEAU   = 64,
  parameter int THR       = 6,
  parameter int FRAME_LEN = 4096
) (
  input logic              clk,
  input logic              reset,
  ofdm_frame_sync_if.slave bus
);
  localparam int WIN  = 1 << WIN_LOG2;
  localparam int PW   = 2 * DATA_SIZE + 1;
  localparam int AW   = PW + WIN_LOG2;
  localparam int CW   = AW + 4;
  localparam int WARM = DELAY + WIN;
  localparam int WCW  = $clog2(WARM + 1);
  localparam int PCW  = $clog2(PLATEAU + 1);

  typedef enum logic [1:0] {SEARCH, COUNT, ARMED, LOCKED} state_t;

  logic signed [DATA_SIZE-1:0] dly_i [DELAY];
  logic signed [DATA_SIZE-1:0] dly_q [DELAY];
  logic signed [PW-1:0]        xi_w, xq_w, yi_w, yq_w;
  logic signed [PW-1:0]        ci_p0, cq_p0;
  logic        [PW-1:0]        r_p0;
  logic                        vld_p0;
  logic signed [PW-1:0]        pd_i [WIN];
  logic signed [PW-1:0]        pd_q [WIN];
  logic        [PW-1:0]        pd_r [WIN];
  logic signed [AW-1:0]        acc_i_p1, acc_q_p1;
  logic        [AW-1:0]        acc_r_p1;
  logic                        vld_p1;
  logic        [CW-1:0]        lhs, rhs;
  logic        [WCW-1:0]       warm_cnt;
  logic                        warm_ok;
  logic                        metric_p2;
  logic                        vld_p2;
  state_t                      state;
  logic        [PCW-1:0]       run_cnt;
  logic                        locked_r;
  logic                        frame_start_r;
  logic                        to_hit;

  function automatic logic [CW-1:0] mag(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] a;
    a = v[AW-1] ? -v : v;
    return CW'($unsigned(a));
  endfunction

  assign xi_w = PW'(bus.in_data_i);
  assign xq_w = PW'(bus.in_data_q);
  assign yi_w = PW'(dly_i[DELAY-1]);
  assign yq_w = PW'(dly_q[DELAY-1]);

  // Stage p0: sample delay line and correlation/power products
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      ci_p0  <= '0;
      cq_p0  <= '0;
      r_p0   <= '0;
      for (int k = 0; k < DELAY; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
    end else if (bus.clear) begin
      vld_p0 <= 1'b0;
      ci_p0  <= '0;
      cq_p0  <= '0;
      r_p0   <= '0;
      for (int k = 0; k < DELAY; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
    end else begin
      vld_p0 <= bus.en;
      if (bus.en) begin
        dly_i[0] <= bus.in_data_i;
        dly_q[0] <= bus.in_data_q;
        for (int k = 1; k < DELAY; k++) begin
          dly_i[k] <= dly_i[k-1];
          dly_q[k] <= dly_q[k-1];
        end
        ci_p0 <= xi_w * yi_w + xq_w * yq_w;
        cq_p0 <= xq_w * yi_w - xi_w * yq_w;
        r_p0  <= $unsigned(yi_w * yi_w + yq_w * yq_w);
      end
    end
  end

  // Stage p1: sliding-window sums over the last WIN products
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      acc_i_p1 <= '0;
      acc_q_p1 <= '0;
      acc_r_p1 <= '0;
      for (int k = 0; k < WIN; k++) begin
        pd_i[k] <= '0;
        pd_q[k] <= '0;
        pd_r[k] <= '0;
      end
    end else if (bus.clear) begin
      vld_p1   <= 1'b0;
      acc_i_p1 <= '0;
      acc_q_p1 <= '0;
      acc_r_p1 <= '0;
      for (int k = 0; k < WIN; k++) begin
        pd_i[k] <= '0;
        pd_q[k] <= '0;
        pd_r[k] <= '0;
      end
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        pd_i[0] <= ci_p0;
        pd_q[0] <= cq_p0;
        pd_r[0] <= r_p0;
        for (int k = 1; k < WIN; k++) begin
          pd_i[k] <= pd_i[k-1];
          pd_q[k] <= pd_q[k-1];
          pd_r[k] <= pd_r[k-1];
        end
        acc_i_p1 <= acc_i_p1 + AW'(ci_p0) - AW'(pd_i[WIN-1]);
        acc_q_p1 <= acc_q_p1 + AW'(cq_p0) - AW'(pd_q[WIN-1]);
        acc_r_p1 <= acc_r_p1 + AW'(r_p0) - AW'(pd_r[WIN-1]);
      end
    end
  end

  assign lhs     = (mag(acc_i_p1) + mag(acc_q_p1)) << 3;
  assign rhs     = CW'(THR) * CW'(acc_r_p1);
  assign warm_ok = (warm_cnt == WCW'(WARM - 1));

  // Stage p2: thresholded metric, held at 0 until the window holds real lagged products
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p2    <= 1'b0;
      metric_p2 <= 1'b0;
      warm_cnt  <= '0;
    end else if (bus.clear) begin
      vld_p2    <= 1'b0;
      metric_p2 <= 1'b0;
      warm_cnt  <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        metric_p2 <= warm_ok && (lhs >= rhs);
        if (!warm_ok) warm_cnt <= warm_cnt + 1'b1;
      end
      if (to_hit) warm_cnt <= '0;
    end
  end

`ifdef OFDM_SYNC_TIMEOUT_EN
  localparam int TW = $clog2(FRAME_LEN + 1);
  logic [TW-1:0] to_cnt;
  assign to_hit = (state == LOCKED) && bus.en && (to_cnt == TW'(FRAME_LEN - 1));
`else
  localparam int unused_frame_len = FRAME_LEN;
  assign to_hit = 1'b0;
`endif

  // Stage p3: plateau FSM; a strobe coinciding with clear is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= SEARCH;
      run_cnt       <= '0;
      locked_r      <= 1'b0;
      frame_start_r <= 1'b0;
`ifdef OFDM_SYNC_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      frame_start_r <= 1'b0;
      if (bus.clear) begin
        state    <= SEARCH;
        run_cnt  <= '0;
        locked_r <= 1'b0;
`ifdef OFDM_SYNC_TIMEOUT_EN
        to_cnt   <= '0;
`endif
      end else begin
        if (vld_p2) begin
          case (state)
            SEARCH: if (metric_p2) begin
              run_cnt <= PCW'(1);
              state   <= COUNT;
            end
            COUNT: if (!metric_p2) begin
              state <= SEARCH;
            end else if (run_cnt == PCW'(PLATEAU - 1)) begin
              state    <= ARMED;
              locked_r <= 1'b1;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
            ARMED: if (!metric_p2) begin
              frame_start_r <= 1'b1;
              state         <= LOCKED;
            end
            default: ;
          endcase
        end
`ifdef OFDM_SYNC_TIMEOUT_EN
        if (to_hit) begin
          state    <= SEARCH;
          locked_r <= 1'b0;
          to_cnt   <= '0;
        end else if (state == LOCKED && bus.en) begin
          to_cnt <= to_cnt + 1'b1;
        end
`endif
      end
    end
  end

  assign bus.locked      = locked_r;
  assign bus.frame_start = frame_start_r;
  assign bus.metric_ok   = metric_p2;
endmodule

// File: tb/tb_ofdm_frame_sync.sv
// Randomised bench for ofdm_frame_sync, scored against a window-sum / run-length reference model.
module tb_ofdm_frame_sync;
  localparam int DW        = 16;
  localparam int DELAY     = 16;
  localparam int WIN_LOG2  = 4;
  localparam int WIN       = 1 << WIN_LOG2;
  localparam int PLATEAU   = 64;
  localparam int THR       = 6;
  localparam int FRAME_LEN = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofdm_frame_sync_if #(.DATA_SIZE(DW)) bus ();

  ofdm_frame_sync #(
    .DATA_SIZE(DW), .DELAY(DELAY), .WIN_LOG2(WIN_LOG2),
    .PLATEAU(PLATEAU), .THR(THR), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 8;
  bit  chk_on = 1'b1;
  bit  hm [8];
  bit  hl [8];
  bit  hf [8];
  int  fs_cnt, fs_cyc, lock_cyc, first_p, last_p;
  bit  prev_l;
  logic signed [DW-1:0] pre_i [16];
  logic signed [DW-1:0] pre_q [16];

  // reference model state: accepted samples since reset/clear and plateau bookkeeping
  longint s_i [$];
  longint s_q [$];
  int     run;
  int     phase;
  bit     cur_m, cur_l;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit calc_metric();
    longint pi, pq, r, xi, xq, yi, yq;
    int n;
    n = s_i.size();
    if (n < DELAY + WIN) return 1'b0;
    pi = 0; pq = 0; r = 0;
    for (int j = n - WIN; j < n; j++) begin
      xi = s_i[j]; xq = s_q[j];
      yi = s_i[j-DELAY]; yq = s_q[j-DELAY];
      pi += xi * yi + xq * yq;
      pq += xq * yi - xi * yq;
      r  += yi * yi + yq * yq;
    end
    if (pi < 0) pi = -pi;
    if (pq < 0) pq = -pq;
    return ((pi + pq) * 8) >= (THR * r);
  endfunction

  task automatic reset_model();
    s_i.delete(); s_q.delete();
    run = 0; phase = 0; cur_m = 1'b0; cur_l = 1'b0;
  endtask

  task automatic model_push(input bit e, input logic signed [DW-1:0] di, input logic signed [DW-1:0] dq, input bit c);
    bit f;
    f = 1'b0;
    if (c) begin
      reset_model();
      for (int k = 0; k < 4; k++) begin
        hm[(cyc-k)&7] = 1'b0; hl[(cyc-k)&7] = 1'b0; hf[(cyc-k)&7] = 1'b0;
      end
    end else begin
      if (e) begin
        s_i.push_back(longint'(di));
        s_q.push_back(longint'(dq));
        cur_m = calc_metric();
        run   = cur_m ? run + 1 : 0;
        if (phase == 0 && run >= PLATEAU) phase = 1;
        else if (phase == 1 && !cur_m) begin
          phase = 2;
          f = 1'b1;
        end
        cur_l = (phase != 0);
      end
      hm[cyc&7] = cur_m; hl[cyc&7] = cur_l; hf[cyc&7] = f;
    end
  endtask

  task automatic observe();
    if (bus.frame_start === 1'b1) begin
      fs_cnt++;
      fs_cyc = cyc;
    end
    if (bus.locked === 1'b1 && !prev_l) lock_cyc = cyc;
    prev_l = (bus.locked === 1'b1);
    if (chk_on) begin
      chk("metric_ok", bus.metric_ok, hm[(cyc-3)&7]);
      chk("locked", bus.locked, hl[(cyc-4)&7]);
      chk("frame_start", bus.frame_start, hf[(cyc-4)&7]);
    end
  endtask

  task automatic step(input bit e, input logic signed [DW-1:0] di, input logic signed [DW-1:0] dq, input bit c);
    bus.en = e; bus.in_data_i = di; bus.in_data_q = dq; bus.clear = c;
    @(posedge clk);
    model_push(e, di, dq, c);
    cyc++;
    #1 observe();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int k = 0; k < n; k++) begin
      bus.en = 1'($urandom); bus.in_data_i = DW'($urandom); bus.in_data_q = DW'($urandom); bus.clear = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_locked", bus.locked, 1'b0);
      chk("rst_frame_start", bus.frame_start, 1'b0);
      chk("rst_metric_ok", bus.metric_ok, 1'b0);
    end
    reset_model();
    for (int k = 0; k < 8; k++) begin hm[k] = 1'b0; hl[k] = 1'b0; hf[k] = 1'b0; end
    prev_l = 1'b0;
    reset  = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic make_pre();
    for (int k = 0; k < 16; k++) begin
      pre_i[k] = ($urandom_range(0, 1) != 0) ? 16'sd8000 : -16'sd8000;
      pre_q[k] = ($urandom_range(0, 1) != 0) ? 16'sd8000 : -16'sd8000;
    end
  endtask

  task automatic send_pre(input int nsamp, input bit toggle);
    for (int k = 0; k < nsamp; k++) begin
      step(1'b1, pre_i[k%16], pre_q[k%16], 1'b0);
      last_p = cyc - 1;
      if (toggle) idle(1);
    end
  endtask

  task automatic send_zeros(input int n, input bit toggle);
    for (int k = 0; k < n; k++) begin
      step(1'b1, '0, '0, 1'b0);
      if (toggle) idle(1);
    end
  endtask

  task automatic send_noise(input int n);
    for (int k = 0; k < n; k++) step(1'b1, DW'($urandom), DW'($urandom), 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.in_data_i = '0; bus.in_data_q = '0; bus.clear = 1'b0;
    prev_l = 1'b0;
    do_reset(5);
    idle(3);

    // ideal continuous preamble
    make_pre();
    fs_cnt = 0; lock_cyc = 0; fs_cyc = 0;
    first_p = cyc;
    send_pre(160, 1'b0);
    send_zeros(64, 1'b0);
    chk("pre_fs_count", fs_cnt, 1);
    chk("pre_locked", bus.locked, 1'b1);
    chk("pre_lock_cycle", lock_cyc - first_p, DELAY + WIN + PLATEAU + 2);
    chk("pre_fs_latency_ok", (fs_cyc - last_p) <= (4 + DELAY), 1'b1);

    // clear while LOCKED
    step(1'b1, DW'($urandom), DW'($urandom), 1'b1);
    chk("clear_unlocks", bus.locked, 1'b0);
    idle(4);

    // short burst then random data
    make_pre();
    fs_cnt = 0;
    send_pre(40, 1'b0);
    send_noise(200);
    chk("burst_fs_count", fs_cnt, 0);
    chk("burst_locked", bus.locked, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    idle(2);

    // uniform random noise
    fs_cnt = 0;
    send_noise(10000);
    chk("noise_fs_count", fs_cnt, 0);
    chk("noise_locked", bus.locked, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    idle(2);

    // preamble with en toggling
    make_pre();
    fs_cnt = 0;
    send_pre(160, 1'b1);
    send_zeros(64, 1'b1);
    chk("stall_fs_count", fs_cnt, 1);
    chk("stall_locked", bus.locked, 1'b1);
    chk("stall_fs_latency_ok", (fs_cyc - last_p) <= 2 * (4 + DELAY), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    idle(2);

    // reset mid-COUNT, then replay
    make_pre();
    send_pre(60, 1'b0);
    chk("midcount_unlocked", bus.locked, 1'b0);
    do_reset(5);
    fs_cnt = 0;
    send_pre(160, 1'b0);
    send_zeros(64, 1'b0);
    chk("replay_fs_count", fs_cnt, 1);
    chk("replay_locked", bus.locked, 1'b1);

`ifdef OFDM_SYNC_TIMEOUT_EN
    chk_on = 1'b0;
    for (int g = 0; g < 400 && cyc < fs_cyc + FRAME_LEN - 1; g++) step(1'b1, '0, '0, 1'b0);
    chk("timeout_hold", bus.locked, 1'b1);
    step(1'b1, '0, '0, 1'b0);
    chk("timeout_release", bus.locked, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    chk_on = 1'b1;
`else
    step(1'b0, '0, '0, 1'b1);
`endif
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
